// File: rtl/uncache_axi_bridge.sv
// uncache_axi_bridge
// ------------------
// Turns level-held uncached read/write requests into single-beat AXI4
// transactions. Only one transaction is in flight at a time. Each finished
// transaction gives a one-cycle reload pulse. Read data is returned on
// rd_data, and bus_err flags a non-OKAY response.
//
// Ports
//   clk, reset                        clock, asynchronous active-high reset
//   rd_req/rd_addr                    read request (held until reload)
//   wr_req/wr_wstrb/wr_addr/wr_data   write request (held until reload)
//   reload, rd_data, bus_err          completion pulse, read data, error pulse
//   ar*/r*                            AXI4 read address / read data channels
//   aw*/w*/b*                         AXI4 write address / data / response
module uncache_axi_bridge #(
  parameter int               ID_WD = 4,
  parameter logic [ID_WD-1:0] RD_ID = 4'd0,
  parameter logic [ID_WD-1:0] WR_ID = 4'd1
) (
  input  logic             clk,
  input  logic             reset,
  // uncache request side
  input  logic             rd_req,
  input  logic [31:0]      rd_addr,
  input  logic             wr_req,
  input  logic [3:0]       wr_wstrb,
  input  logic [31:0]      wr_addr,
  input  logic [31:0]      wr_data,
  output logic             reload,
  output logic [31:0]      rd_data,
  output logic             bus_err,
  // AXI read address
  output logic [ID_WD-1:0] arid,
  output logic [31:0]      araddr,
  output logic [7:0]       arlen,
  output logic [2:0]       arsize,
  output logic [1:0]       arburst,
  output logic             arvalid,
  input  logic             arready,
  // AXI read data
  input  logic [ID_WD-1:0] rid,
  input  logic [31:0]      rdata,
  input  logic [1:0]       rresp,
  input  logic             rlast,
  input  logic             rvalid,
  output logic             rready,
  // AXI write address
  output logic [ID_WD-1:0] awid,
  output logic [31:0]      awaddr,
  output logic [7:0]       awlen,
  output logic [2:0]       awsize,
  output logic [1:0]       awburst,
  output logic             awvalid,
  input  logic             awready,
  // AXI write data
  output logic [31:0]      wdata,
  output logic [3:0]       wstrb,
  output logic             wlast,
  output logic             wvalid,
  input  logic             wready,
  // AXI write response
  input  logic [ID_WD-1:0] bid,
  input  logic [1:0]       bresp,
  input  logic             bvalid,
  output logic             bready
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW_W = 3'd3,
    S_B    = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] araddr_q, araddr_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        err_q, err_d;
  // Set once the AW or W handshake has happened. The two channels finish
  // independently.
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic aw_hs;
  logic w_hs;

  // Fixed single-beat, 32-bit, INCR transaction shape.
  assign arid    = RD_ID;
  assign arlen   = 8'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign awid    = WR_ID;
  assign awlen   = 8'd0;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign wlast   = 1'b1;

  // All valid/ready strobes are decoded from state, so an asynchronous
  // reset forces them low immediately.
  assign arvalid = (state_q == S_AR);
  assign rready  = (state_q == S_R);
  assign awvalid = (state_q == S_AW_W) && !aw_done_q;
  assign wvalid  = (state_q == S_AW_W) && !w_done_q;
  assign bready  = (state_q == S_B);
  assign reload  = (state_q == S_DONE);
  assign bus_err = (state_q == S_DONE) && err_q;

  assign araddr  = araddr_q;
  assign awaddr  = awaddr_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign rd_data = rd_data_q;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  // Response IDs and rlast carry no information for single-beat,
  // single-outstanding traffic.
  logic unused_inputs;
  assign unused_inputs = ^{rid, rlast, bid};

  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rd_data_d = rd_data_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    unique case (state_q)
      S_IDLE: begin
        // The write is checked first so a buffered store stays ahead of a
        // later load.
        if (wr_req) begin
          awaddr_d  = wr_addr;
          wdata_d   = wr_data;
          wstrb_d   = wr_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          err_d     = 1'b0;
          state_d   = S_AW_W;
        end else if (rd_req) begin
          araddr_d = rd_addr;
          err_d    = 1'b0;
          state_d  = S_AR;
        end
      end
      S_AR: begin
        if (arready) state_d = S_R;
      end
      S_R: begin
        if (rvalid) begin
          rd_data_d = rdata;
          err_d     = (rresp != 2'b00);
          state_d   = S_DONE;
        end
      end
      S_AW_W: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = S_B;
      end
      S_B: begin
        if (bvalid) begin
          err_d   = (bresp != 2'b00);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      araddr_q  <= 32'd0;
      awaddr_q  <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      rd_data_q <= 32'd0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_uncache_axi_bridge.sv
module tb_uncache_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        wr_req;
  logic [3:0]  wr_wstrb;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        reload;
  logic [31:0] rd_data;
  logic        bus_err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int checks   = 0;
  int failures = 0;

  uncache_axi_bridge dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr),
    .wr_req(wr_req), .wr_wstrb(wr_wstrb), .wr_addr(wr_addr), .wr_data(wr_data),
    .reload(reload), .rd_data(rd_data), .bus_err(bus_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rd_req = 0; rd_addr = 0; wr_req = 0; wr_wstrb = 0; wr_addr = 0; wr_data = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    step(); step();

    // ---- reset state and constants
    chk("rst_arvalid", 32'(arvalid), 0);
    chk("rst_awvalid", 32'(awvalid), 0);
    chk("rst_wvalid", 32'(wvalid), 0);
    chk("rst_rready", 32'(rready), 0);
    chk("rst_bready", 32'(bready), 0);
    chk("rst_reload", 32'(reload), 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wstrb", 32'(wstrb), 0);
    chk("const_ar", {arid, arlen, arsize, arburst}, {4'd0, 8'd0, 3'b010, 2'b01});
    chk("const_aw", {awid, awlen, awsize, awburst, wlast}, {4'd1, 8'd0, 3'b010, 2'b01, 1'b1});
    reset = 1'b0;
    step();

    // ---- 1: read, zero-wait slave (rvalid early must be ignored)
    rd_req = 1; rd_addr = 32'h1FAF_F000;
    arready = 1; rvalid = 1; rdata = 32'hDEAD_BEEF; rresp = 0;
    #1;
    chk("rd_c0_rready", 32'(rready), 0);
    step();  // cycle 1
    chk("rd_c1_arvalid", 32'(arvalid), 1);
    chk("rd_c1_araddr", araddr, 32'h1FAF_F000);
    chk("rd_c1_reload", 32'(reload), 0);
    step();  // cycle 2
    chk("rd_c2_arvalid", 32'(arvalid), 0);
    chk("rd_c2_rready", 32'(rready), 1);
    step();  // cycle 3
    chk("rd_c3_reload", 32'(reload), 1);
    chk("rd_c3_rd_data", rd_data, 32'hDEAD_BEEF);
    chk("rd_c3_bus_err", 32'(bus_err), 0);
    rd_req = 0; rvalid = 0; arready = 0;
    step();
    chk("rd_c4_reload", 32'(reload), 0);
    chk("rd_c4_arvalid", 32'(arvalid), 0);
    $display("txn1 read addr=1faff000 data=%h", rd_data);

    // ---- 2: write, awready delayed, wready immediate
    wr_req = 1; wr_addr = 32'h0000_1000; wr_data = 32'h1234_5678; wr_wstrb = 4'b0011;
    awready = 0; wready = 1; bvalid = 0;
    step();  // cycle 1
    chk("wr_c1_awvalid", 32'(awvalid), 1);
    chk("wr_c1_wvalid", 32'(wvalid), 1);
    chk("wr_c1_awaddr", awaddr, 32'h0000_1000);
    chk("wr_c1_wdata", wdata, 32'h1234_5678);
    chk("wr_c1_wstrb", 32'(wstrb), 32'h3);
    step();  // cycle 2
    chk("wr_c2_wvalid", 32'(wvalid), 0);
    chk("wr_c2_awvalid", 32'(awvalid), 1);
    chk("wr_c2_bready", 32'(bready), 0);
    step();  // cycle 3
    chk("wr_c3_awvalid", 32'(awvalid), 1);
    step();  // cycle 4
    chk("wr_c4_awvalid", 32'(awvalid), 1);
    chk("wr_c4_bready", 32'(bready), 0);
    awready = 1;
    step();  // cycle 5
    chk("wr_c5_awvalid", 32'(awvalid), 0);
    chk("wr_c5_bready", 32'(bready), 1);
    chk("wr_c5_reload", 32'(reload), 0);
    awready = 0; bvalid = 1; bresp = 0;
    step();  // cycle 6
    chk("wr_c6_reload", 32'(reload), 1);
    chk("wr_c6_bus_err", 32'(bus_err), 0);
    chk("wr_c6_rd_data", rd_data, 32'hDEAD_BEEF);
    wr_req = 0; bvalid = 0;
    step();
    chk("wr_c7_reload", 32'(reload), 0);
    $display("txn2 write addr=00001000 data=12345678 strb=3");

    // ---- 3: both requests together -> write first, then read
    wr_req = 1; wr_addr = 32'h0000_2000; wr_data = 32'hAAAA_0001; wr_wstrb = 4'hF;
    rd_req = 1; rd_addr = 32'h0000_3000;
    awready = 1; wready = 1; bvalid = 1; arready = 1; rvalid = 1; rdata = 32'hCAFE_F00D;
    step();
    chk("both_c1_awvalid", 32'(awvalid), 1);
    chk("both_c1_arvalid", 32'(arvalid), 0);
    step();
    chk("both_c2_bready", 32'(bready), 1);
    step();
    chk("both_c3_reload", 32'(reload), 1);
    wr_req = 0;
    step();
    chk("both_c4_idle_arvalid", 32'(arvalid), 0);
    chk("both_c4_reload", 32'(reload), 0);
    step();
    chk("both_c5_arvalid", 32'(arvalid), 1);
    chk("both_c5_araddr", araddr, 32'h0000_3000);
    step();
    step();
    chk("both_c7_reload", 32'(reload), 1);
    chk("both_c7_rd_data", rd_data, 32'hCAFE_F00D);
    rd_req = 0;
    step();
    $display("txn3 write-then-read rd_data=%h", rd_data);

    // ---- 4: back-to-back writes
    wr_req = 1; wr_addr = 32'h0000_4000; wr_data = 32'h1111_1111;
    step();
    chk("b2b_c1_awaddr", awaddr, 32'h0000_4000);
    step();
    step();
    chk("b2b_c3_reload", 32'(reload), 1);
    wr_addr = 32'h0000_4004; wr_data = 32'h2222_2222;
    step();
    chk("b2b_c4_awvalid", 32'(awvalid), 0);
    step();
    chk("b2b_c5_awvalid", 32'(awvalid), 1);
    chk("b2b_c5_awaddr", awaddr, 32'h0000_4004);
    chk("b2b_c5_wdata", wdata, 32'h2222_2222);
    step();
    step();
    chk("b2b_c7_reload", 32'(reload), 1);
    wr_req = 0;
    step();
    step();
    chk("b2b_c9_no_dup", 32'(awvalid), 0);
    $display("txn4 back-to-back writes last addr=%h", awaddr);

    // ---- 5: SLVERR read, then OKAY write
    bvalid = 0;
    rd_req = 1; rd_addr = 32'h0000_5000; rdata = 32'h0BAD_F00D; rresp = 2'b10;
    step();
    step();
    step();
    chk("err_c3_reload", 32'(reload), 1);
    chk("err_c3_bus_err", 32'(bus_err), 1);
    chk("err_c3_rd_data", rd_data, 32'h0BAD_F00D);
    rd_req = 0; rresp = 0;
    wr_req = 1; wr_addr = 32'h0000_6000; bvalid = 1; bresp = 0;
    step();
    chk("err_c4_bus_err", 32'(bus_err), 0);
    step();
    step();
    step();
    chk("err_wr_reload", 32'(reload), 1);
    chk("err_wr_bus_err", 32'(bus_err), 0);
    wr_req = 0; bvalid = 0;
    step();
    $display("txn5 slverr read then okay write");

    // ---- 6: async reset while in R with rvalid pending
    rd_req = 1; rd_addr = 32'h0000_7000; arready = 1; rvalid = 0;
    step();
    step();
    chk("rst_r_rready", 32'(rready), 1);
    rvalid = 1; rdata = 32'h5555_5555;
    #1 reset = 1;
    #1;
    chk("arst_rready", 32'(rready), 0);
    chk("arst_reload", 32'(reload), 0);
    chk("arst_araddr", araddr, 0);
    chk("arst_rd_data", rd_data, 0);
    step();
    chk("arst_edge_reload", 32'(reload), 0);
    rdata = 32'h0000_0077;
    reset = 0;
    step();
    chk("post_c1_arvalid", 32'(arvalid), 1);
    chk("post_c1_araddr", araddr, 32'h0000_7000);
    step();
    step();
    chk("post_c3_reload", 32'(reload), 1);
    chk("post_c3_rd_data", rd_data, 32'h0000_0077);
    rd_req = 0; rvalid = 0;
    step();
    $display("txn6 reset-in-R then read data=%h", rd_data);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
